// File: rtl/vga_console_writer_if.sv
// vga_console_writer_if: byte handshake from the CPU plus the char RAM port owned by the writer
interface vga_console_writer_if #(parameter int AW = 13) ();
  logic          ch_valid;
  logic [7:0]    ch_data;
  logic          ch_ready;
  logic          vram_sel;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [6:0]    vram_wdata;
  logic [6:0]    vram_rdata;
  modport master (output ch_valid, ch_data, vram_rdata, input ch_ready, vram_sel, vram_we, vram_addr, vram_wdata);
  modport slave  (input ch_valid, ch_data, vram_rdata, output ch_ready, vram_sel, vram_we, vram_addr, vram_wdata);
endinterface

// File: rtl/vga_console_writer.sv
// vga_console_writer: putchar front end that places, wraps, scrolls and clears the 80x60 text char RAM
module vga_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int AW   = 13
) (
  input  logic                sys_clk,
  input  logic                clrn,
  vga_console_writer_if.slave bus,
  output logic [5:0]          cursor_row,
  output logic [6:0]          cursor_col,
  output logic                busy
);
  typedef enum logic [2:0] {IDLE, PUT, ADV, SCR_RD, SCR_WR, SCR_CLR, CLR} state_t;
  localparam logic [6:0]    CMAX     = 7'(COLS - 1);
  localparam logic [5:0]    RMAX     = 6'(ROWS - 1);
  localparam logic [AW-1:0] CW       = AW'(COLS);
  localparam logic [AW-1:0] SCR_LAST = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] LAST     = AW'(ROWS * COLS - 1);
  state_t        st, st_n;
  logic [7:0]    b, b_n;
  logic [5:0]    row_n;
  logic [6:0]    col_n;
  logic [AW-1:0] ptr, ptr_n, cur_addr;
  logic [6:0]    rd, rd_n;
  logic          acc;
  assign acc      = bus.ch_valid & bus.ch_ready;
  assign busy     = st != IDLE;
  // row*80 as row*64 + row*16
  assign cur_addr = (AW'(cursor_row) << 6) + (AW'(cursor_row) << 4) + AW'(cursor_col);
  always_comb begin
    st_n           = st;
    b_n            = b;
    row_n          = cursor_row;
    col_n          = cursor_col;
    ptr_n          = ptr;
    rd_n           = rd;
    bus.ch_ready   = st == IDLE;
    bus.vram_sel   = 1'b0;
    bus.vram_we    = 1'b0;
    bus.vram_addr  = '0;
    bus.vram_wdata = '0;
    case (st)
      IDLE: if (acc) begin
        b_n = bus.ch_data;
        if (bus.ch_data inside {[8'h20:8'h7e]}) st_n = PUT;
        else if (bus.ch_data == 8'h0a) begin
          col_n = '0;
          st_n  = ADV;
        end else if (bus.ch_data == 8'h0d) col_n = '0;
        else if (bus.ch_data == 8'h08 && cursor_col != '0) begin
          col_n = cursor_col - 7'd1;
          st_n  = PUT;
        end else if (bus.ch_data == 8'h0c) begin
          row_n = '0;
          col_n = '0;
          ptr_n = '0;
          st_n  = CLR;
        end
      end
      PUT: begin
        bus.vram_sel   = 1'b1;
        bus.vram_we    = 1'b1;
        bus.vram_addr  = cur_addr;
        bus.vram_wdata = b == 8'h08 ? 7'h20 : b[6:0];
        // backspace erases in place without advancing
        st_n  = b != 8'h08 && cursor_col == CMAX ? ADV : IDLE;
        col_n = b == 8'h08 ? cursor_col : cursor_col == CMAX ? 7'd0 : cursor_col + 7'd1;
      end
      ADV: begin
        st_n  = cursor_row == RMAX ? SCR_RD : IDLE;
        row_n = cursor_row == RMAX ? cursor_row : cursor_row + 6'd1;
        ptr_n = '0;
      end
      SCR_RD: begin
        bus.vram_sel  = 1'b1;
        bus.vram_addr = ptr + CW;
        rd_n          = bus.vram_rdata;
        st_n          = SCR_WR;
      end
      SCR_WR: begin
        bus.vram_sel   = 1'b1;
        bus.vram_we    = 1'b1;
        bus.vram_addr  = ptr;
        bus.vram_wdata = rd;
        ptr_n          = ptr + 1'b1;
        st_n           = ptr == SCR_LAST ? SCR_CLR : SCR_RD;
      end
      SCR_CLR, CLR: begin
        bus.vram_sel   = 1'b1;
        bus.vram_we    = 1'b1;
        bus.vram_addr  = ptr;
        bus.vram_wdata = 7'h20;
        ptr_n          = ptr + 1'b1;
        st_n           = ptr == LAST ? IDLE : st;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge clrn)
    if (!clrn) begin
      st         <= IDLE;
      b          <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      ptr        <= '0;
      rd         <= '0;
    end else begin
      st         <= st_n;
      b          <= b_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      ptr        <= ptr_n;
      rd         <= rd_n;
    end
endmodule

// File: tb/tb_vga_console_writer.sv
// tb_vga_console_writer: directed putchar, wrap, control-code, scroll and clear checks against a char RAM model
module tb_vga_console_writer;
  logic sys_clk = 1'b0;
  logic clrn = 1'b0;
  always #10 sys_clk = ~sys_clk;
  vga_console_writer_if #(.AW(13)) bus ();
  logic [5:0] cursor_row;
  logic [6:0] cursor_col;
  logic       busy;
  vga_console_writer dut (.sys_clk(sys_clk), .clrn(clrn), .bus(bus.slave),
                          .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy));
  logic [6:0] ram [0:4799];
  logic init_req = 1'b0;
  int wcnt = 0, scnt = 0, checks = 0, errors = 0;
  assign bus.vram_rdata = bus.vram_sel ? ram[bus.vram_addr] : 7'h00;
  function automatic logic [6:0] f(int i);
    return (i >= 80 && i < 160) ? 7'(i - 79) : 7'((i % 90) + 33);
  endfunction
  function automatic logic [6:0] g(int i);
    return i < 4720 ? f(i + 80) : 7'h20;
  endfunction
  always @(posedge sys_clk) begin
    if (init_req) for (int i = 0; i < 4800; i++) ram[i] <= f(i);
    else if (bus.vram_sel && bus.vram_we) ram[bus.vram_addr] <= bus.vram_wdata;
    if (bus.vram_we) wcnt <= wcnt + 1;
    if (bus.vram_sel) scnt <= scnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge sys_clk);
    while (!bus.ch_ready && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!bus.ch_ready) chk("ready_timeout", 0, 1);
    bus.ch_valid = 1'b1;
    bus.ch_data  = d;
    @(posedge sys_clk);
    #1;
    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", 0, 1);
  endtask
  task automatic do_reset();
    clrn = 1'b0;
    @(posedge sys_clk);
    #1;
    clrn = 1'b1;
  endtask
  initial begin
    int n, w0, s0, bad;
    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_ready", bus.ch_ready, 1);
    chk("rst_sel", bus.vram_sel, 0);
    chk("rst_we", bus.vram_we, 0);
    chk("rst_addr", bus.vram_addr, 0);
    chk("rst_wdata", bus.vram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_col", cursor_col, 0);
    clrn = 1'b1;
    send(8'h41);
    chk("a_we", bus.vram_we, 1);
    chk("a_addr", bus.vram_addr, 0);
    chk("a_wdata", bus.vram_wdata, 8'h41);
    chk("a_ready_low", bus.ch_ready, 0);
    @(posedge sys_clk);
    #1;
    chk("a_ready_back", bus.ch_ready, 1);
    chk("a_col", cursor_col, 1);
    chk("a_row", cursor_row, 0);
    send(8'h01);
    chk("ign_busy", busy, 0);
    chk("ign_col", cursor_col, 1);
    do_reset();
    repeat (5) send(8'h0a);
    repeat (79) send(8'h78);
    send(8'h5a);
    chk("wrap_we", bus.vram_we, 1);
    chk("wrap_addr", bus.vram_addr, 479);
    chk("wrap_wdata", bus.vram_wdata, 8'h5a);
    wait_idle(n);
    chk("wrap_cycles", n, 2);
    chk("wrap_row", cursor_row, 6);
    chk("wrap_col", cursor_col, 0);
    do_reset();
    repeat (3) send(8'h0a);
    repeat (10) send(8'h61);
    wait_idle(n);
    w0 = wcnt;
    send(8'h0a);
    wait_idle(n);
    chk("lf_row", cursor_row, 4);
    chk("lf_col", cursor_col, 0);
    send(8'h0d);
    chk("cr_busy", busy, 0);
    chk("cr_row", cursor_row, 4);
    chk("cr_col", cursor_col, 0);
    chk("lfcr_nowrite", wcnt - w0, 0);
    do_reset();
    repeat (2) send(8'h0a);
    wait_idle(n);
    w0 = wcnt;
    send(8'h08);
    chk("bs0_busy", busy, 0);
    chk("bs0_row", cursor_row, 2);
    chk("bs0_col", cursor_col, 0);
    repeat (7) send(8'h62);
    wait_idle(n);
    chk("bs0_nowrite", wcnt - w0, 7);
    send(8'h08);
    chk("bs_we", bus.vram_we, 1);
    chk("bs_addr", bus.vram_addr, 166);
    chk("bs_wdata", bus.vram_wdata, 8'h20);
    wait_idle(n);
    chk("bs_row", cursor_row, 2);
    chk("bs_col", cursor_col, 6);
    chk("bs_ram", ram[166], 8'h20);
    do_reset();
    init_req = 1'b1;
    @(posedge sys_clk);
    #1;
    init_req = 1'b0;
    repeat (59) send(8'h0a);
    wait_idle(n);
    chk("scr_pre_row", cursor_row, 59);
    s0 = scnt;
    send(8'h0a);
    wait_idle(n);
    chk("scr_sel_cycles", scnt - s0, 9520);
    chk("scr_row", cursor_row, 59);
    chk("scr_col", cursor_col, 0);
    chk("scr_ram0", ram[0], 1);
    chk("scr_ram79", ram[79], 80);
    chk("scr_ram4799", ram[4799], 8'h20);
    bad = 0;
    for (int i = 0; i < 4800; i++) if (ram[i] !== g(i)) bad++;
    chk("scr_ram_bad", bad, 0);
    send(8'h0c);
    chk("ff_busy", busy, 1);
    chk("ff_row", cursor_row, 0);
    chk("ff_col", cursor_col, 0);
    repeat (100) @(posedge sys_clk);
    #1;
    clrn = 1'b0;
    #1;
    chk("abort_ready", bus.ch_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_we", bus.vram_we, 0);
    chk("abort_sel", bus.vram_sel, 0);
    chk("abort_row", cursor_row, 0);
    chk("abort_col", cursor_col, 0);
    bad = 0;
    for (int i = 0; i < 4800; i++) if (ram[i] !== (i < 100 ? 7'h20 : g(i))) bad++;
    chk("abort_ram_bad", bad, 0);
    @(posedge sys_clk);
    #1;
    clrn = 1'b1;
    w0 = wcnt;
    send(8'h0c);
    wait_idle(n);
    chk("clr_writes", wcnt - w0, 4800);
    chk("clr_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 4800; i++) if (ram[i] !== 7'h20) bad++;
    chk("clr_ram_bad", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_console_writer.md
Name: vga_console_writer

Overview:
- Character-stream front end for the 80x60 text-mode char RAM scanned by the VGA text display.
- Accepts one byte at a time over a valid/ready handshake and keeps a hardware cursor.
- Turns printable bytes and control codes into char RAM read/write cycles: it places characters, wraps lines, scrolls the screen up one row and clears the screen.
- The CPU issues a putchar; it does not compute addresses.

Parameters:
COLS, 80, characters per row
ROWS, 60, character rows
AW, 13, char RAM address width (COLS*ROWS = 4800 cells)

Ports:
sys_clk  in  1  system clock, 50 MHz
clrn  in  1  asynchronous active-low reset
ch_valid  in  1  byte offered on ch_data
ch_data  in  8  character or control byte
ch_ready  out  1  block can accept a byte this cycle
vram_sel  out  1  block owns char RAM address port this cycle (muxes vram_addr over VGA scan address)
vram_we  out  1  char RAM write strobe, sampled at sys_clk rising edge
vram_addr  out  AW  char RAM cell address = row*COLS + col
vram_wdata  out  7  ASCII written to char RAM
vram_rdata  in  7  char RAM read data, combinational from vram_addr while vram_sel=1
cursor_row  out  6  current cursor row, 0..ROWS-1
cursor_col  out  7  current cursor column, 0..COLS-1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE; cursor_row=0, cursor_col=0.
  - ch_ready=1, vram_sel=0, vram_we=0, vram_addr=0, vram_wdata=0, busy=0.
  - Reset mid-scroll or mid-clear aborts immediately. RAM contents are left partially updated. Reset never clears RAM.
- Handshake:
  - ch_ready=1 only in IDLE. A byte is accepted when ch_valid&ch_ready at a rising edge.
  - ch_data is latched on acceptance. ch_data need not stay stable afterwards.
  - ch_ready drops the cycle after acceptance.
- States: IDLE, PUT, ADV, SCR_RD, SCR_WR, SCR_CLR, CLR.
- IDLE, on acceptance, decodes the latched byte:
  - 0x20..0x7E -> PUT.
  - 0x0A (LF) -> col=0, then ADV.
  - 0x0D (CR) -> col=0, stay IDLE.
  - 0x08 (BS) -> if col>0: col-1 and PUT with wdata 0x20, cursor not advanced. If col=0: no-op.
  - 0x0C (FF) -> CLR.
  - All other bytes are consumed and ignored.
- PUT (1 cycle):
  - vram_sel=1, vram_we=1, addr=row*COLS+col, wdata=byte[6:0].
  - If col<COLS-1: col+1, then IDLE. If col=COLS-1: col=0, then ADV.
  - A printable byte occupies 2 cycles from acceptance to ch_ready=1 when no wrap occurs.
- ADV (1 cycle): if row<ROWS-1: row+1, then IDLE. Else row stays ROWS-1, then SCR_RD with src=COLS, dst=0.
- Scroll:
  - SCR_RD: vram_sel=1, vram_we=0, addr=src; latch vram_rdata.
  - SCR_WR: vram_sel=1, vram_we=1, addr=dst, wdata=latched data; then src+1, dst+1.
  - After writing dst=(ROWS-1)*COLS-1 (4719), go to SCR_CLR.
  - SCR_CLR writes 0x20 at 4720..4799, one cell per cycle, then IDLE.
  - Scroll cost: 2*4720+80 = 9520 cycles.
- CLR:
  - Writes 0x20 at addresses 0..4799, one per cycle (4800 cycles).
  - Cursor is set to 0,0 on entry. Then IDLE.
- Arithmetic:
  - Address is computed as (row<<6)+(row<<4)+col, 13 bits, no multiplier.
  - Cursor never exceeds ROWS-1 / COLS-1.
- vram_sel=0 in IDLE so the VGA scan owns the RAM. The block tolerates VGA display artefacts during scroll/clear.

Test Plan:
1. Reset, send 'A'(0x41) at cursor 0,0 -> one cycle with vram_we=1, addr=0, wdata=0x41; then cursor_col=1; ch_ready back 2 cycles after acceptance.
2. Cursor at row 5, col 79, send 'Z' -> write addr 479 (5*80+79), cursor becomes row 6, col 0; no scroll.
3. Cursor row 3, col 10, send LF then CR -> after LF cursor 4,0; after CR cursor unchanged at 4,0; no vram_we pulses.
4. Cursor 2,0, send BS -> no write, cursor stays 2,0. Then from 2,7 send BS -> write 0x20 at addr 166, cursor 2,6.
5. Preload RAM[80+i]=i+1 for i=0..79 and row 59 nonzero; cursor 59,0; send LF -> busy for 9520 cycles; RAM[0..79]=1..80; RAM[4720..4799]=0x20; cursor 59,0.
6. Send FF, assert clrn=0 after 100 cycles -> immediate IDLE, cursor 0,0, vram_we=0; RAM[0..99]=0x20, RAM[100..] untouched. Re-send FF -> 4800 writes of 0x20, busy deasserts.
